bcd_display_scanner: RTL
========================

// Module: bcd_display_scanner
// PURPOSE
//  Upstream stage of the 7-segment path. Accepts a binary value over a valid/ready handshake.
//  Converts it to packed BCD sequentially, one double-dabble shift per cycle, and holds the result.
//  Time-multiplexes the digits, presenting one 4-bit BCD nibble at a time on bcd_out.
//  bcd_out feeds the 4-bit bcd input of the BCD-to-7-segment encoder; dig_sel drives the digit commons.
// PARAMETERS
//  DIGITS    4      number of displayed digits (1..8)
//  BIN_W     14     width of binary input (14 covers 0..9999)
//  SCAN_DIV  50000  clk cycles per digit slot (>=2)
// PORTS
//  clk       in   1         system clock, rising edge
//  rst       in   1         synchronous reset, active-high
//  bin_in    in   BIN_W     binary value to display
//  in_valid  in   1         bin_in valid
//  in_ready  out  1         block can accept bin_in
//  conv_done out  1         1-cycle pulse: new digits committed
//  ovf       out  1         last committed value exceeded 10^DIGITS-1
//  bcd_out   out  4         BCD nibble of the currently scanned digit (to encoder bcd)
//  dig_sel   out  DIGITS    one-hot digit enable, active-high; bit 0 = least significant digit
// BEHAVIOUR
//  Reset (rst=1 at an edge): all of the following are cleared or forced.
//   - FSM goes to IDLE; digit register goes to 0; ovf=0; conv_done=0.
//   - Prescaler = 0; scan index = 0; bcd_out=4'h0; dig_sel=1.
//   - Reset in any state aborts a conversion in progress; the partial result is discarded.
//  in_ready = (state==IDLE). It is combinational, so it reads 1 during reset.
//  Transfer: in_valid & in_ready at an edge. bin_in is captured into a shift register.
//   - The BCD accumulator (4*DIGITS bits) is cleared at the same edge.
//   - ovf_next = (bin_in > 10^DIGITS-1) is latched at the same edge.
//  FSM states: IDLE -> CONV -> COMMIT -> IDLE.
//   - IDLE: waits for a transfer. in_valid while busy is ignored and causes no queueing.
//   - CONV: exactly BIN_W cycles. Each cycle every BCD nibble >=5 gets +3, then {bcd,bin} shifts left 1.
//   - COMMIT: 1 cycle. Digit register <= ovf_next ? all 4'h9 : accumulator. ovf <= ovf_next.
//     conv_done=1 in the cycle after the COMMIT edge.
//  Latency: the transfer at edge k gives new digits visible from edge k+BIN_W+1.
//   - in_ready is 0 for BIN_W+1 cycles after the transfer.
//   - Back-to-back transfers are possible: the next one is accepted one cycle after conv_done.
//  Scan: the prescaler runs freely, counting 0..SCAN_DIV-1 and wrapping.
//   - At terminal count the scan index advances by 1, wrapping DIGITS-1 -> 0.
//  Scan outputs are registered, so each change appears one cycle after the index changes.
//   - bcd_out = digit[idx]; dig_sel = 1<<idx.
//  No tearing: the display reads only the committed digit register.
//   - The old value is shown throughout CONV.
//   - A COMMIT coinciding with an index advance shows the new digit in the new slot.
//  bcd_out is always a legal BCD code 0..9 (or 4'hF when blanked, see below).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: blank a digit when it and every more significant digit are 0.
//   - A blanked digit is never digit 0. In its slot dig_sel=0 and bcd_out=4'hF.
//   - Value 0 therefore shows a single "0".
//  LEADING_ZERO_BLANK_EN undefined: all DIGITS slots are always enabled and leading zeros are displayed.
// TESTING
//  Use DIGITS=4, BIN_W=14, SCAN_DIV=4 unless noted.
//  1. Reset: hold rst 3 cycles, then release.
//     -> in_ready=1, dig_sel=4'b0001, bcd_out=0, ovf=0, conv_done=0.
//     -> dig_sel walks 0001->0010->0100->1000->0001, changing every 4 cycles.
//  2. Conversion: send bin_in=1234 with in_valid.
//     -> in_ready=0 for 15 cycles, conv_done pulses once.
//     -> Slots show 4,3,2,1 on bcd_out for dig_sel 0001,0010,0100,1000.
//  3. Overflow: send bin_in=12000.
//     -> ovf=1, every slot shows 9.
//     -> A following send of bin_in=0 clears ovf=0.
//  4. Busy: pulse in_valid with 77 while the FSM is in CONV for a prior 5678.
//     -> 77 is ignored, display 5678, exactly one conv_done.
//  5. Reset mid-conversion: assert rst at CONV cycle 7 of 9999.
//     -> Digits are all 0, no conv_done, in_ready=1 the next cycle.
//  6. With LEADING_ZERO_BLANK_EN, send 42.
//     -> Slots 2,3: dig_sel=0, bcd_out=4'hF. Slots 0,1 show 2,4.
//     -> Sending 0 shows only digit 0 enabled, value 0.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: value handshake and digit-scan outputs of the BCD display scanner.
interface bcd_display_scanner_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic in_valid;
  logic in_ready;
  logic conv_done;
  logic ovf;
  logic [3:0] bcd_out;
  logic [DIGITS-1:0] dig_sel;
  modport master (output bin_in, in_valid, input in_ready, conv_done, ovf, bcd_out, dig_sel);
  modport slave (input bin_in, in_valid, output in_ready, conv_done, ovf, bcd_out, dig_sel);
endinterface

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: sequential double-dabble binary-to-BCD with time-multiplexed digit scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_scanner #(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14,
  parameter int SCAN_DIV = 50000
) (
  input logic clk,
  input logic rst,
  bcd_display_scanner_if.slave bus
);
  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int unsigned MAX_V = 10 ** DIGITS - 1;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t state_q, state_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [AW-1:0] acc_q, acc_d, adj, dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] bcd_q, bcd_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic ovf_q, ovf_d, ovfn_q, ovfn_d, done_q, done_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic nz;
`endif
  assign bus.in_ready = state_q == IDLE;
  assign bus.conv_done = done_q;
  assign bus.ovf = ovf_q;
  assign bus.bcd_out = bcd_q;
  assign bus.dig_sel = sel_q;
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    state_d = state_q;
    sh_d = sh_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    dig_d = dig_q;
    ovf_d = ovf_q;
    ovfn_d = ovfn_q;
    done_d = 1'b0;
    if (state_q == IDLE && bus.in_valid) begin
      state_d = CONV;
      sh_d = bus.bin_in;
      acc_d = '0;
      cnt_d = '0;
      ovfn_d = 32'(bus.bin_in) > MAX_V;
    end else if (state_q == CONV) begin
      {acc_d, sh_d} = {adj, sh_q} << 1;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(BIN_W - 1) ? COMMIT : CONV;
    end else if (state_q == COMMIT) begin
      dig_d = ovfn_q ? {DIGITS{4'h9}} : acc_q;
      ovf_d = ovfn_q;
      done_d = 1'b1;
      state_d = IDLE;
    end
    // Scan reads only the committed register, so a conversion never tears the display.
    presc_d = presc_q == PW'(SCAN_DIV - 1) ? '0 : presc_q + 1'b1;
    idx_d = presc_q != PW'(SCAN_DIV - 1) ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    nz = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz = nz | (dig_q[4*i +: 4] != 4'h0);
      blank[i] = ~nz;
    end
    bcd_d = blank[idx_q] ? 4'hF : dig_q[4*idx_q +: 4];
    sel_d = blank[idx_q] ? '0 : DIGITS'(1) << idx_q;
`else
    bcd_d = dig_q[4*idx_q +: 4];
    sel_d = DIGITS'(1) << idx_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      dig_q <= '0;
      ovf_q <= 1'b0;
      ovfn_q <= 1'b0;
      done_q <= 1'b0;
      presc_q <= '0;
      idx_q <= '0;
      bcd_q <= 4'h0;
      sel_q <= DIGITS'(1);
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      ovf_q <= ovf_d;
      ovfn_q <= ovfn_d;
      done_q <= done_d;
      presc_q <= presc_d;
      idx_q <= idx_d;
      bcd_q <= bcd_d;
      sel_q <= sel_d;
    end
  end
endmodule
